// File: rtl/alu_share_ctrl.sv
// Arbitration and sequencing controller in front of a shared 32-bit ALU.
// Two valid/ready requesters are served round robin, and each result is returned as a tagged one-cycle pulse.
module alu_share_ctrl #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [2:0]        req0_op_i,
    input  logic [DATA_W-1:0] req0_data1_i,
    input  logic [DATA_W-1:0] req0_data2_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [2:0]        req1_op_i,
    input  logic [DATA_W-1:0] req1_data1_i,
    input  logic [DATA_W-1:0] req1_data2_i,
    output logic              resp0_valid_o,
    output logic              resp1_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_err_o,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [2:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              busy_o
);

    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, res_q, res_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d, tag_q, tag_d, rr_q, rr_d;
    logic              can_grant, gnt0, gnt1;
    logic [2:0]        sel_op;
    logic              sel_illegal;

    // rr_q holds the last granted index; on a tie the other requester wins.
    always_comb begin
        can_grant = (state_q != S_EXEC) && !rst_i;
        gnt0      = can_grant && req0_valid_i && (!req1_valid_i || rr_q);
        gnt1      = can_grant && req1_valid_i && (!req0_valid_i || !rr_q);
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    assign sel_op      = gnt1 ? req1_op_i : req0_op_i;
    assign sel_illegal = sel_op[2] && (sel_op[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        res_d   = res_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tag_d   = tag_q;
        rr_d    = rr_q;
        case (state_q)
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = err_q ? '0 : alu_data_i;
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (gnt0 || gnt1) begin
                    d1_d    = gnt1 ? req1_data1_i : req0_data1_i;
                    d2_d    = gnt1 ? req1_data2_i : req0_data2_i;
                    ctrl_d  = sel_illegal ? 3'b000 : sel_op;
                    err_d   = sel_illegal;
                    tag_d   = gnt1;
                    rr_d    = gnt1;
                    cnt_d   = (sel_op == OP_MUL) ? MUL_CNT : 4'd0;
                    state_d = S_EXEC;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            d1_q    <= '0;
            d2_q    <= '0;
            res_q   <= '0;
            ctrl_q  <= 3'b000;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            tag_q   <= 1'b0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            res_q   <= res_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            rr_q    <= rr_d;
        end
    end

    // ALU inputs come straight from the latched registers, so they hold between ops.
    assign alu_data1_o   = d1_q;
    assign alu_data2_o   = d2_q;
    assign alu_ctrl_o    = ctrl_q;
    assign busy_o        = (state_q == S_EXEC);
    assign resp0_valid_o = (state_q == S_RESP) && !tag_q;
    assign resp1_valid_o = (state_q == S_RESP) && tag_q;
    assign resp_data_o   = res_q;
    assign resp_err_o    = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios followed by random traffic.
// A transaction-level model predicts grants and tagged responses.
module tb_alu_share_ctrl;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rdy0, rdy1;
    logic [2:0]  op0, op1, alu_ctrl;
    logic [31:0] a0, b0, a1, b1, rdata, alu_d1, alu_d2, alu_res;
    logic        rv0, rv1, rerr, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          at;
        bit          tag;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   next_grant = 0;
    bit   last = 1'b1;

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // The ALU sitting behind the controller.
    assign alu_res = ref_alu(alu_ctrl, alu_d1, alu_d2);

    alu_share_ctrl #(.DATA_W(32), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op_i(op0),
        .req0_data1_i(a0), .req0_data2_i(b0),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op_i(op1),
        .req1_data1_i(a1), .req1_data2_i(b1),
        .resp0_valid_o(rv0), .resp1_valid_o(rv1),
        .resp_data_o(rdata), .resp_err_o(rerr),
        .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_ctrl_o(alu_ctrl),
        .alu_data_i(alu_res), .busy_o(busy)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: check grants and responses against the model, then advance.
    task automatic step();
        bit   g0, g1, idx;
        int   lat;
        exp_t e;
        #1;
        g0 = 0;
        g1 = 0;
        if (!rst && cyc >= next_grant) begin
            g0 = v0 && (!v1 || last);
            g1 = v1 && (!v0 || !last);
        end
        chk("ready0", rdy0, g0);
        chk("ready1", rdy1, g1);
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            chk("resp0_valid", rv0, !e.tag);
            chk("resp1_valid", rv1, e.tag);
            chk("resp_data", rdata, e.data);
            chk("resp_err", rerr, e.err);
        end else begin
            chk("resp0_idle", rv0, 0);
            chk("resp1_idle", rv1, 0);
        end
        if (rst) begin
            exp_q.delete();
            next_grant = cyc + 1;
            last = 1'b1;
        end else if (g0 || g1) begin
            idx    = g1;
            e.tag  = idx;
            lat    = ((idx ? op1 : op0) == 3'd4) ? MUL_LAT : 1;
            e.at   = cyc + 1 + lat;
            e.data = idx ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
            e.err  = (idx ? op1 : op0) > 3'd4;
            exp_q.push_back(e);
            next_grant = cyc + 1 + lat;
            last = idx;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(bit who, bit v, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (who) begin v1 = v; op1 = op; a1 = a; b1 = b; end
        else     begin v0 = v; op0 = op; a0 = a; b0 = b; end
    endtask

    // Single-cycle op from one requester, with constant checks on ctrl and result.
    task automatic single(bit who, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] expd, bit experr);
        drive(who, 1, op, a, b);
        step();
        drive(who, 0, 3'd0, 32'd0, 32'd0);
        chk("exec_ctrl", alu_ctrl, (op > 3'd4) ? 3'd0 : op);
        chk("exec_busy", busy, 1);
        step();
        chk("single_valid", who ? rv1 : rv0, 1);
        chk("single_data", rdata, expd);
        chk("single_err", rerr, experr);
        step();
    endtask

    initial begin
        rst = 1;
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        drive(1, 0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 0;
        #1;
        chk("rst_ready0", rdy0, 0);
        chk("rst_ready1", rdy1, 0);
        chk("rst_data", rdata, 0);
        chk("rst_err", rerr, 0);
        chk("rst_alu1", alu_d1, 0);
        chk("rst_alu2", alu_d2, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_busy", busy, 0);
        step();

        // add 5+7 on req0
        single(0, 3'd0, 32'd5, 32'd7, 32'd12, 0);

        // mul 6*7 on req1, operands change after accept
        drive(1, 1, 3'd4, 32'd6, 32'd7);
        step();
        drive(1, 0, 3'd4, 32'd99, 32'd123);
        for (int k = 0; k < MUL_LAT; k++) begin
            chk("mul_hold1", alu_d1, 6);
            chk("mul_hold2", alu_d2, 7);
            chk("mul_ctrl", alu_ctrl, 4);
            chk("mul_busy", busy, 1);
            step();
        end
        chk("mul_resp1", rv1, 1);
        chk("mul_data", rdata, 42);
        step();

        // both valid continuously: grants alternate via the model
        drive(0, 1, 3'd1, 32'd9, 32'd4);
        drive(1, 1, 3'd3, 32'hF0, 32'h0F);
        for (int k = 0; k < 12; k++) step();
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        drive(1, 0, 3'd0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) step();

        // illegal op
        single(0, 3'd7, 32'd3, 32'd4, 32'd0, 1);

        // reset during the second EXEC cycle of a mul
        drive(1, 1, 3'd4, 32'd11, 32'd13);
        step();
        drive(1, 0, 3'd0, 32'd0, 32'd0);
        step();
        rst = 1;
        step();
        rst = 0;
        chk("midrst_state_busy", busy, 0);
        chk("midrst_resp0", rv0, 0);
        chk("midrst_resp1", rv1, 0);
        chk("midrst_data", rdata, 0);
        chk("midrst_alu1", alu_d1, 0);
        chk("midrst_alu2", alu_d2, 0);
        chk("midrst_ctrl", alu_ctrl, 0);
        drive(1, 1, 3'd0, 32'd1, 32'd2);
        drive(0, 1, 3'd0, 32'd3, 32'd4);
        #1;
        chk("post_rst_rdy0", rdy0, 1);
        chk("post_rst_rdy1", rdy1, 0);
        step();
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        drive(1, 0, 3'd0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) step();

        // wrap and mask boundaries
        single(0, 3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
        single(1, 3'd2, 32'hFFFF_0000, 32'h00FF_FF00, 32'h00FF_0000, 0);

        // random traffic including dropped valids and occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 60) == 0);
            drive(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            drive(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            step();
        end
        rst = 0;
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        drive(1, 0, 3'd0, 32'd0, 32'd0);
        for (int k = 0; k < 8; k++) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
